// File: rtl/if_id_pkg.sv
// Shared types and constants for the IF/ID decoupling buffer.
// The optional IF_ID_BYPASS_EN build changes only the top level.
package if_id_pkg;

  localparam int INSTR_W      = 32;
  localparam int XLEN         = 64;
  localparam int CACHE_WORD_W = 64;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               misaligned;
  } if_id_entry_t;

  // pc[2] picks the upper or lower half of the 64-bit cache word.
  function automatic if_id_entry_t make_entry(input logic [XLEN-1:0]         pc,
                                              input logic [CACHE_WORD_W-1:0] word);
    if_id_entry_t e;
    e.pc         = pc;
    e.instr      = pc[2] ? word[CACHE_WORD_W-1:INSTR_W] : word[INSTR_W-1:0];
    e.misaligned = |pc[1:0];
    return e;
  endfunction

endpackage

// File: rtl/if_id_fifo.sv
// DEPTH-entry circular queue of if_id_entry_t with synchronous clear.
// The caller guarantees no push when full and no pop when empty.
module if_id_fifo
  import if_id_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  if_id_entry_t             push_data,
  input  logic                     pop,
  output if_id_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  if_id_entry_t     mem_r [DEPTH];

  // Storage, pointers and occupancy; clear resets bookkeeping but keeps stale data.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: fetch acknowledge, flush/discard handling, word selection.
// Build option IF_ID_BYPASS_EN forwards a fetch straight to the decoder when empty.
module if_id_buffer
  import if_id_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [CACHE_WORD_W-1:0]  in_word,
  input  logic                     in_fetch_busy,
  output logic                     in_ack,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic                     out_misaligned,
  output logic [$clog2(DEPTH):0]   count
);

  logic         in_ack_r;
  logic         discard_r;
  logic         accept_s;
  logic         capture_s;
  logic         write_s;
  logic         bypass_s;
  logic         push_s;
  logic         pop_s;
  logic         fifo_full_s;
  logic         fifo_empty_s;
  if_id_entry_t new_entry_s;
  if_id_entry_t head_s;

  assign new_entry_s = make_entry(in_pc, in_word);

  // Capture/write decisions; a capture during flush is acked but never stored.
  always_comb begin
    accept_s  = in_valid && !in_ack_r;
    capture_s = accept_s && (!fifo_full_s || flush);
    write_s   = capture_s && !flush && !discard_r;
`ifdef IF_ID_BYPASS_EN
    bypass_s  = fifo_empty_s && write_s;
`else
    bypass_s  = 1'b0;
`endif
    push_s    = write_s && !(bypass_s && out_ready);
    pop_s     = !fifo_empty_s && out_ready && !flush;
  end

  // Decoder-facing outputs: queue head, or the incoming fetch when bypassing.
  always_comb begin
    out_valid      = 1'b0;
    out_pc         = head_s.pc;
    out_instr      = head_s.instr;
    out_misaligned = head_s.misaligned;
    if (bypass_s) begin
      out_valid      = 1'b1;
      out_pc         = new_entry_s.pc;
      out_instr      = new_entry_s.instr;
      out_misaligned = new_entry_s.misaligned;
    end else begin
      out_valid      = !fifo_empty_s;
    end
  end

  // One-cycle ack per capture; discard marks a fetch in flight across a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ack_r  <= 1'b0;
      discard_r <= 1'b0;
    end else begin
      in_ack_r <= capture_s;
      if (flush && in_fetch_busy && !accept_s) begin
        discard_r <= 1'b1;
      end else if (capture_s) begin
        discard_r <= 1'b0;
      end else begin
        discard_r <= discard_r;
      end
    end
  end

  if_id_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push_s),
    .push_data (new_entry_s),
    .pop       (pop_s),
    .head      (head_s),
    .count     (count),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  assign in_ack = in_ack_r;

endmodule

// File: tb/tb_if_id_buffer.sv
// Self-checking bench for if_id_buffer: directed scenarios plus a randomized
// run against a queue-based reference model of the buffer's rules.
module tb_if_id_buffer;

  localparam int DEPTH = 2;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic [63:0]      in_pc;
  logic [63:0]      in_word;
  logic             in_fetch_busy;
  logic             in_ack;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [63:0]      out_pc;
  logic [31:0]      out_instr;
  logic             out_misaligned;
  logic [CNT_W-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  if_id_buffer #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_pc          (in_pc),
    .in_word        (in_word),
    .in_fetch_busy  (in_fetch_busy),
    .in_ack         (in_ack),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misaligned (out_misaligned),
    .count          (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_fetch_busy = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_pc = 64'h0; in_word = 64'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", in_ack); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (count !== CNT_W'(0)) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h want 0", out_instr); end
    checks++; if (out_misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis: got %b want 0", out_misaligned); end
    reset = 1'b0;
  endtask

  task automatic test_single_fetch();
    do_reset();
    in_valid = 1'b1; in_pc = 64'h1004; in_word = 64'hAAAA_BBBB_CCCC_DDDD;
    tick();
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL single_ack: got %b want 1", in_ack); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", out_valid); end
    checks++; if (out_pc !== 64'h1004) begin errors++; $display("FAIL single_pc: got %h want 1004", out_pc); end
    checks++; if (out_instr !== 32'hAAAA_BBBB) begin errors++; $display("FAIL single_instr: got %h want aaaabbbb", out_instr); end
    checks++; if (out_misaligned !== 1'b0) begin errors++; $display("FAIL single_mis: got %b want 0", out_misaligned); end
    in_valid = 1'b0;
    tick();
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL single_ack_fall: got %b want 0", in_ack); end
    checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL single_count: got %0d want 1", count); end
  endtask

  task automatic test_held_valid();
    do_reset();
    in_valid = 1'b1; in_pc = 64'h2000; in_word = 64'h0123_4567_89AB_CDEF;
    tick();
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL held_ack: got %b want 1", in_ack); end
    tick();
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL held_no_reack: got %b want 0", in_ack); end
    checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL held_count: got %0d want 1", count); end
    in_valid = 1'b0;
    tick();
    checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL held_count2: got %0d want 1", count); end
    checks++; if (out_instr !== 32'h89AB_CDEF) begin errors++; $display("FAIL held_instr: got %h want 89abcdef", out_instr); end
  endtask

  task automatic test_full();
    do_reset();
    in_valid = 1'b1; in_pc = 64'h1000; in_word = 64'h1111_1111_A000_1000;
    tick(); in_valid = 1'b0; tick();
    in_valid = 1'b1; in_pc = 64'h1004; in_word = 64'hA000_1004_2222_2222;
    tick();
    checks++; if (count !== CNT_W'(2)) begin errors++; $display("FAIL full_count: got %0d want 2", count); end
    in_valid = 1'b0; tick();
    in_valid = 1'b1; in_pc = 64'h1008; in_word = 64'h3333_3333_A000_1008;
    tick();
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL full_no_ack: got %b want 0", in_ack); end
    tick();
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL full_no_ack2: got %b want 0", in_ack); end
    out_ready = 1'b1;
    checks++; if (out_pc !== 64'h1000) begin errors++; $display("FAIL full_order0: got %h want 1000", out_pc); end
    tick();
    out_ready = 1'b0;
    checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL full_after_pop: got %0d want 1", count); end
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL full_ack_early: got %b want 0", in_ack); end
    tick();
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL full_ack_late: got %b want 1", in_ack); end
    checks++; if (count !== CNT_W'(2)) begin errors++; $display("FAIL full_refill: got %0d want 2", count); end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (out_pc !== 64'h1004) begin errors++; $display("FAIL full_order1: got %h want 1004", out_pc); end
    checks++; if (out_instr !== 32'hA000_1004) begin errors++; $display("FAIL full_instr1: got %h want a0001004", out_instr); end
    tick();
    checks++; if (out_pc !== 64'h1008) begin errors++; $display("FAIL full_order2: got %h want 1008", out_pc); end
    checks++; if (out_instr !== 32'hA000_1008) begin errors++; $display("FAIL full_instr2: got %h want a0001008", out_instr); end
    tick();
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_flush_capture();
    do_reset();
    in_valid = 1'b1; in_pc = 64'h3000; in_word = 64'h1;
    tick(); in_valid = 1'b0; tick();
    in_valid = 1'b1; in_pc = 64'h3004; in_word = 64'h2;
    tick(); in_valid = 1'b0; tick();
    in_valid = 1'b1; in_pc = 64'h3008; in_word = 64'h3; flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== CNT_W'(0)) begin errors++; $display("FAIL flushcap_count: got %0d want 0", count); end
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL flushcap_ack: got %b want 1", in_ack); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flushcap_valid: got %b want 0", out_valid); end
    tick();
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL flushcap_ack_once: got %b want 0", in_ack); end
    checks++; if (count !== CNT_W'(0)) begin errors++; $display("FAIL flushcap_count2: got %0d want 0", count); end
  endtask

  task automatic test_flush_discard();
    do_reset();
    in_fetch_busy = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (4) tick();
    in_valid = 1'b1; in_pc = 64'h4000; in_word = 64'h5555_5555_6666_6666;
    tick();
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL discard_ack: got %b want 1", in_ack); end
    checks++; if (count !== CNT_W'(0)) begin errors++; $display("FAIL discard_count: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL discard_valid: got %b want 0", out_valid); end
    in_valid = 1'b0; in_fetch_busy = 1'b0;
    tick();
    in_valid = 1'b1; in_pc = 64'h4008; in_word = 64'h7777_7777_8888_8888;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== CNT_W'(1)) begin errors++; $display("FAIL discard_next_count: got %0d want 1", count); end
    checks++; if (out_pc !== 64'h4008) begin errors++; $display("FAIL discard_next_pc: got %h want 4008", out_pc); end
    checks++; if (out_instr !== 32'h8888_8888) begin errors++; $display("FAIL discard_next_instr: got %h want 88888888", out_instr); end
  endtask

  task automatic test_misaligned();
    do_reset();
    in_valid = 1'b1; in_pc = 64'h2002; in_word = 64'h1111_2222_3333_4444;
`ifdef IF_ID_BYPASS_EN
    out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mis_bypass_valid: got %b want 1", out_valid); end
    checks++; if (out_misaligned !== 1'b1) begin errors++; $display("FAIL mis_bypass_flag: got %b want 1", out_misaligned); end
    checks++; if (out_instr !== 32'h3333_4444) begin errors++; $display("FAIL mis_bypass_instr: got %h want 33334444", out_instr); end
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== CNT_W'(0)) begin errors++; $display("FAIL mis_bypass_count: got %0d want 0", count); end
    checks++; if (in_ack !== 1'b1) begin errors++; $display("FAIL mis_bypass_ack: got %b want 1", in_ack); end
`else
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mis_valid: got %b want 1", out_valid); end
    checks++; if (out_misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag: got %b want 1", out_misaligned); end
    checks++; if (out_pc !== 64'h2002) begin errors++; $display("FAIL mis_pc: got %h want 2002", out_pc); end
    checks++; if (out_instr !== 32'h3333_4444) begin errors++; $display("FAIL mis_instr: got %h want 33334444", out_instr); end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1; in_pc = 64'h5000; in_word = 64'h9;
    tick(); in_valid = 1'b0; tick();
    in_valid = 1'b1; in_pc = 64'h5004; in_word = 64'hA;
    tick();
    reset = 1'b1; in_valid = 1'b0;
    tick();
    reset = 1'b0;
    checks++; if (in_ack !== 1'b0) begin errors++; $display("FAIL rstmid_ack: got %b want 0", in_ack); end
    checks++; if (count !== CNT_W'(0)) begin errors++; $display("FAIL rstmid_count: got %0d want 0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
    checks++; if (out_pc !== 64'h0) begin errors++; $display("FAIL rstmid_pc: got %h want 0", out_pc); end
  endtask

  task automatic test_random();
    ent_t mq[$];
    ent_t exp_e;
    bit   m_ack, m_disc, acc, cap, wr, byp, exp_v;
    do_reset();
    m_ack = 1'b0; m_disc = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      reset = ($urandom_range(0, 149) == 0);
      if (reset) begin
        in_valid = 1'b0;
      end else if (in_valid && m_ack) begin
        in_valid = 1'b0;
      end else if (!in_valid && !m_ack && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b1;
        in_pc    = {$urandom, $urandom};
        in_word  = {$urandom, $urandom};
      end
      in_fetch_busy = in_valid ? 1'b1 : 1'($urandom_range(0, 1));
      flush         = ($urandom_range(0, 11) == 0);
      out_ready     = 1'($urandom_range(0, 1));
      #1;
      acc = in_valid && !m_ack;
      cap = acc && (mq.size() < DEPTH || flush);
      wr  = cap && !flush && !m_disc;
      byp = 1'b0;
      exp_v = (mq.size() > 0);
      if (exp_v) exp_e = mq[0];
`ifdef IF_ID_BYPASS_EN
      if (mq.size() == 0 && wr) begin
        byp = 1'b1; exp_v = 1'b1;
        exp_e.pc = in_pc;
        exp_e.instr = in_pc[2] ? in_word[63:32] : in_word[31:0];
        exp_e.mis = (in_pc[1:0] != 2'b00);
      end
`endif
      checks++; if (in_ack !== m_ack) begin errors++; $display("FAIL rnd_ack c%0d: got %b want %b", cyc, in_ack, m_ack); end
      checks++; if (count !== CNT_W'(mq.size())) begin errors++; $display("FAIL rnd_count c%0d: got %0d want %0d", cyc, count, mq.size()); end
      checks++; if (out_valid !== exp_v) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, out_valid, exp_v); end
      if (exp_v) begin
        checks++; if (out_pc !== exp_e.pc) begin errors++; $display("FAIL rnd_pc c%0d: got %h want %h", cyc, out_pc, exp_e.pc); end
        checks++; if (out_instr !== exp_e.instr) begin errors++; $display("FAIL rnd_instr c%0d: got %h want %h", cyc, out_instr, exp_e.instr); end
        checks++; if (out_misaligned !== exp_e.mis) begin errors++; $display("FAIL rnd_mis c%0d: got %b want %b", cyc, out_misaligned, exp_e.mis); end
      end
      if (reset) begin
        mq.delete(); m_ack = 1'b0; m_disc = 1'b0;
      end else begin
        if (flush) begin
          mq.delete();
        end else begin
          if (mq.size() > 0 && out_ready) void'(mq.pop_front());
          if (wr && !(byp && out_ready)) begin
            exp_e.pc = in_pc;
            exp_e.instr = in_pc[2] ? in_word[63:32] : in_word[31:0];
            exp_e.mis = (in_pc[1:0] != 2'b00);
            mq.push_back(exp_e);
          end
        end
        if (flush && in_fetch_busy && !acc) m_disc = 1'b1;
        else if (cap) m_disc = 1'b0;
        m_ack = cap;
      end
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_single_fetch();
    test_held_valid();
    test_full();
    test_flush_capture();
    test_flush_discard();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
